// File: rtl/alu_op_pkg.sv
// Operation encoding and execute-unit FSM state shared by ALU control decode and execute stage.
// The decode stage is meant to emit alu_op_e directly.
package alu_op_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_XOR = 4'b0001,
        OP_OR  = 4'b0010,
        OP_ADD = 4'b0011,
        OP_SUB = 4'b0100,
        OP_EQ  = 4'b0101,
        OP_NE  = 4'b0110,
        OP_LT  = 4'b0111,
        OP_GE  = 4'b1000,
        OP_SRL = 4'b1001,
        OP_SLL = 4'b1010,
        OP_SRA = 4'b1011,
        OP_LUI = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_HOLD  = 2'b10
    } exec_state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath for every non-shift operation.
// Shift codes and the unused 1101-1111 codes yield zero here; shifts are handled by the iterative shifter.
module alu_comb
    import alu_op_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            operation,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic [DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic                  lt;
    logic                  eq;

    assign sum  = src_a + src_b;
    assign diff = src_a - src_b;
    assign lt   = $signed(src_a) < $signed(src_b);
    assign eq   = (src_a == src_b);

    always_comb begin
        result = '0;
        case (operation)
            OP_AND:  result = src_a & src_b;
            OP_XOR:  result = src_a ^ src_b;
            OP_OR:   result = src_a | src_b;
            OP_ADD:  result = sum;
            OP_SUB:  result = diff;
            OP_EQ:   result = DATA_WIDTH'(eq);
            OP_NE:   result = DATA_WIDTH'(!eq);
            OP_LT:   result = DATA_WIDTH'(lt);
            OP_GE:   result = DATA_WIDTH'(!lt);
            OP_LUI:  result = src_b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: one-cycle ops via alu_comb, SLL/SRL/SRA shifted one bit per cycle.
// A single op is in flight; in_ready stalls the pipeline while shifting or while a result is held.
module alu_exec_unit
    import alu_op_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult
);

    exec_state_e           state_reg;
    logic [SHAMT_W-1:0]    count_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] result_reg;
    logic [3:0]            shift_op_reg;

    logic [DATA_WIDTH-1:0] shift_next;
    logic [DATA_WIDTH-1:0] comb_result;
    logic [SHAMT_W-1:0]    shamt;
    logic                  accept;
    logic                  shift_left;
    logic                  shift_arith;

    alu_comb #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu_comb (
        .operation (Operation),
        .src_a     (SrcA),
        .src_b     (SrcB),
        .result    (comb_result)
    );

    assign shamt       = SrcB[SHAMT_W-1:0];
    assign in_ready    = (state_reg == ST_IDLE) || ((state_reg == ST_HOLD) && out_ready);
    assign accept      = in_valid && in_ready && !flush;
    assign out_valid   = (state_reg == ST_HOLD);
    assign ALUResult   = result_reg;
    assign shift_left  = (shift_op_reg == OP_SLL);
    assign shift_arith = (shift_op_reg == OP_SRA);

    // One-bit step of the shifter: each bit takes its lower or upper neighbour.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift_bit
        logic from_lo;
        logic from_hi;
        if (gi == 0) begin : g_lsb
            assign from_lo = 1'b0;
        end else begin : g_lo
            assign from_lo = shift_reg[gi-1];
        end
        if (gi == DATA_WIDTH - 1) begin : g_msb
            assign from_hi = shift_arith & shift_reg[DATA_WIDTH-1];
        end else begin : g_hi
            assign from_hi = shift_reg[gi+1];
        end
        assign shift_next[gi] = shift_left ? from_lo : from_hi;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            shift_reg    <= '0;
            result_reg   <= '0;
            shift_op_reg <= '0;
        end else if (flush) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
        end else if (accept) begin
            if (is_shift_op(Operation) && (shamt != '0)) begin
                shift_reg    <= SrcA;
                count_reg    <= shamt;
                shift_op_reg <= Operation;
                state_reg    <= ST_SHIFT;
            end else begin
                // A zero-distance shift is just SrcA, so it completes like any one-cycle op.
                result_reg <= is_shift_op(Operation) ? SrcA : comb_result;
                state_reg  <= ST_HOLD;
            end
        end else begin
            case (state_reg)
                ST_SHIFT: begin
                    shift_reg <= shift_next;
                    count_reg <= count_reg - SHAMT_W'(1);
                    if (count_reg == SHAMT_W'(1)) begin
                        result_reg <= shift_next;
                        state_reg  <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
